ray_pixel_sequencer: RTL and testbench



---
 rtl/ray_pixel_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ray_pixel_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ray_pixel_sequencer.sv
// rtl/ray_pixel_sequencer.sv - frame-scan coordinate issuer with a STAGES-deep valid/x/y pipeline
module ray_pixel_sequencer #(
  parameter int H_RES   = 800,
  parameter int V_RES   = 600,
  parameter int COORD_W = 10,
  parameter int STAGES  = 4,
  parameter int FCNT_W  = 16
) (
  input  logic               clk_in,
  input  logic               reset_btn,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic               stall,
  output logic [STAGES-1:0]  stage_valid,
  output logic [COORD_W-1:0] issue_x,
  output logic [COORD_W-1:0] issue_y,
  output logic               out_valid,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               busy,
  output logic               frame_done,
  output logic [FCNT_W-1:0]  frame_cnt
);

  // Last positions on the step-2 grids and for each row parity.
  localparam int LX2 = (H_RES - 1) - ((H_RES - 1) % 2);
  localparam int LYE = (V_RES - 1) - ((V_RES - 1) % 2);
  localparam int LYO = (((V_RES - 1) % 2) == 1) ? (V_RES - 1) : (V_RES - 2);

  localparam logic [COORD_W-1:0] LAST_X1 = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] LAST_X2 = COORD_W'(LX2);
  localparam logic [COORD_W-1:0] LAST_Y1 = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] LAST_YE = COORD_W'(LYE);
  localparam logic [COORD_W-1:0] LAST_YO = COORD_W'(LYO);

  typedef enum logic [1:0] {IDLE, INIT, ISSUE, DRAIN} state_t;

  state_t              state, state_n;
  logic [COORD_W-1:0]  x, y, x_n, y_n;
  logic [COORD_W-1:0]  last_x, last_y, x_step, y_step;
  logic [1:0]          mode_q, mode_n;
  logic                start_pend, pend_n, done_n, load0, load_valid;
  logic [FCNT_W-1:0]   cnt_n;
  logic [COORD_W-1:0]  pipe_x [STAGES];
  logic [COORD_W-1:0]  pipe_y [STAGES];

  always_comb begin
    last_x = (mode_q == 2'b11) ? LAST_X2 : LAST_X1;
    x_step = (mode_q == 2'b11) ? COORD_W'(2) : COORD_W'(1);
    y_step = (mode_q == 2'b00) ? COORD_W'(1) : COORD_W'(2);
    case (mode_q)
      2'b00:   last_y = LAST_Y1;
      2'b10:   last_y = LAST_YO;
      default: last_y = LAST_YE;
    endcase
  end

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    mode_n     = mode_q;
    pend_n     = start_pend;
    done_n     = 1'b0;
    cnt_n      = frame_cnt;
    load0      = 1'b0;
    load_valid = 1'b0;
    if (abort) begin
      state_n = IDLE;
      pend_n  = 1'b0;
    end else if (!stall) begin
      if (start && state != IDLE) pend_n = 1'b1;
      case (state)
        IDLE: begin
          if (start || start_pend) begin
            state_n = INIT;
            pend_n  = 1'b0;
          end
        end
        INIT: begin
          mode_n  = mode;
          x_n     = '0;
          y_n     = (mode == 2'b10) ? COORD_W'(1) : COORD_W'(0);
          state_n = ISSUE;
        end
        ISSUE: begin
          load0      = 1'b1;
          load_valid = 1'b1;
          if (x == last_x) begin
            x_n = '0;
            y_n = y + y_step;
            if (y == last_y) state_n = DRAIN;
          end else begin
            x_n = x + x_step;
          end
        end
        DRAIN: begin
          load0 = 1'b1;
          if (stage_valid[STAGES-2:0] == '0) begin
            done_n  = 1'b1;
            cnt_n   = frame_cnt + 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      mode_q     <= '0;
      start_pend <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      mode_q     <= mode_n;
      start_pend <= pend_n;
      frame_done <= done_n;
      frame_cnt  <= cnt_n;
      busy       <= (state_n != IDLE);
    end
  end

  // Stage 0 only takes new data in ISSUE/DRAIN; upper stages shift on every unstalled edge.
  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      stage_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        pipe_x[i] <= '0;
        pipe_y[i] <= '0;
      end
    end else if (abort) begin
      stage_valid <= '0;
    end else if (!stall) begin
      stage_valid <= {stage_valid[STAGES-2:0], load0 ? load_valid : stage_valid[0]};
      for (int i = 1; i < STAGES; i++) begin
        pipe_x[i] <= pipe_x[i-1];
        pipe_y[i] <= pipe_y[i-1];
      end
      if (load0 && load_valid) begin
        pipe_x[0] <= x;
        pipe_y[0] <= y;
      end
    end
  end

  assign issue_x   = pipe_x[0];
  assign issue_y   = pipe_y[0];
  assign out_x     = pipe_x[STAGES-1];
  assign out_y     = pipe_y[STAGES-1];
  assign out_valid = stage_valid[STAGES-1];

endmodule

// File: tb/tb_ray_pixel_sequencer.sv
// tb/tb_ray_pixel_sequencer.sv - table-driven frame checks with an output-coordinate scoreboard
module tb_ray_pixel_sequencer;
  localparam int H = 4, V = 3, ST = 4, CW = 10, FW = 16;

  logic          clk_in = 0, reset_btn = 0, start = 0, abort = 0, stall = 0;
  logic [1:0]    mode = 0;
  logic [ST-1:0] stage_valid;
  logic [CW-1:0] issue_x, issue_y, out_x, out_y;
  logic          out_valid, busy, frame_done;
  logic [FW-1:0] frame_cnt;

  ray_pixel_sequencer #(.H_RES(H), .V_RES(V), .COORD_W(CW), .STAGES(ST), .FCNT_W(FW)) dut (
    .clk_in(clk_in), .reset_btn(reset_btn), .start(start), .abort(abort), .mode(mode),
    .stall(stall), .stage_valid(stage_valid), .issue_x(issue_x), .issue_y(issue_y),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt));

  always #5 clk_in = ~clk_in;

  typedef struct {int x; int y;} xy_t;
  typedef struct {logic [1:0] mode; int n; int first; int done;} vec_t;

  xy_t  exp_q[$];
  vec_t tbl[4];
  int   n_vec = 0, n_fail = 0, pops = 0, cnt_exp = 0;
  int   kd, kf, seen;
  logic adv = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_frame(input logic [1:0] m);
    int xs, ys, y0;
    xs = (m == 2'b11) ? 2 : 1;
    ys = (m == 2'b00) ? 1 : 2;
    y0 = (m == 2'b10) ? 1 : 0;
    for (int yy = y0; yy < V; yy += ys)
      for (int xx = 0; xx < H; xx += xs)
        exp_q.push_back('{xx, yy});
  endtask

  // A new output appears only after an edge that was not stalled.
  always @(posedge clk_in) adv <= !stall;

  always @(negedge clk_in) begin : mon
    xy_t e;
    if (out_valid && adv) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_x", out_x, e.x);
        check("sb_y", out_y, e.y);
      end
    end
  end

  task automatic wait_done(input int k0, input int bound, output int k_done, output int k_first);
    k_done  = -1;
    k_first = -1;
    for (int k = k0 + 1; k <= bound; k++) begin
      step();
      if (out_valid && k_first < 0) k_first = k;
      if (frame_done) begin
        k_done = k;
        return;
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input string name);
    int p0, d, f;
    p0 = pops;
    push_frame(v.mode);
    mode  = v.mode;
    start = 1;
    step();
    start = 0;
    wait_done(0, 100, d, f);
    cnt_exp++;
    check({name, "_done_edge"}, d, v.done);
    check({name, "_first_out"}, f, v.first);
    step();
    check({name, "_done_pulse"}, frame_done, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_cnt"}, frame_cnt, cnt_exp);
    check({name, "_npix"}, pops - p0, v.n);
    check({name, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    tbl[0] = '{2'b00, 12, 5, 17};
    tbl[1] = '{2'b01,  8, 5, 13};
    tbl[2] = '{2'b10,  4, 5,  9};
    tbl[3] = '{2'b11,  4, 5,  9};

    #1 reset_btn = 1;
    repeat (2) step();
    check("rst_sv", stage_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_ix", issue_x, 0);
    reset_btn = 0;
    step();

    for (int i = 0; i < 4; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // stall for three edges once (1,0) sits in stage 0
    push_frame(2'b00); mode = 2'b00; start = 1; step(); start = 0;
    repeat (3) step();
    check("stall_pre_sv", stage_valid, 4'b0011);
    check("stall_pre_ix", issue_x, 1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_sv", stage_valid, 4'b0011);
      check("stall_ix", issue_x, 1);
      check("stall_iy", issue_y, 0);
    end
    stall = 0;
    wait_done(6, 100, kd, kf);
    cnt_exp++;
    check("stall_done_edge", kd, 20);
    step();
    check("stall_cnt", frame_cnt, cnt_exp);
    check("stall_q_empty", exp_q.size(), 0);

    // start while busy queues one more frame
    push_frame(2'b00); start = 1; step(); start = 0;
    repeat (7) step();
    start = 1; step(); start = 0;
    push_frame(2'b00);
    wait_done(8, 100, kd, kf);
    cnt_exp++;
    check("pend_done1", kd, 17);
    check("pend_busy_low", busy, 0);
    step();
    check("pend_init_busy", busy, 1);
    wait_done(18, 100, kd, kf);
    cnt_exp++;
    check("pend_done2", kd, 35);
    step();
    check("pend_cnt", frame_cnt, cnt_exp);
    check("pend_q_empty", exp_q.size(), 0);
    check("pend_idle", busy, 0);

    // abort sampled at E8
    push_frame(2'b00); start = 1; step(); start = 0;
    repeat (7) step();
    abort = 1; step(); abort = 0;
    check("abort_sv", stage_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_q_left", exp_q.size(), 9);
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (frame_done) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_cnt", frame_cnt, cnt_exp);
    run_frame(tbl[0], "abort_rerun");

    // abort together with start, with a request already pending
    push_frame(2'b00); start = 1; step(); start = 0;
    repeat (2) step();
    start = 1; step(); start = 0;
    step();
    abort = 1; start = 1; step(); abort = 0; start = 0;
    check("abst_busy", busy, 0);
    exp_q.delete();
    repeat (3) step();
    check("abst_stay_idle", busy, 0);
    check("abst_sv", stage_valid, 0);

    // asynchronous reset during DRAIN
    push_frame(2'b00); start = 1; step(); start = 0;
    repeat (15) step();
    check("rst_pre_busy", busy, 1);
    reset_btn = 1;
    #1;
    check("arst_sv", stage_valid, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt", frame_cnt, 0);
    check("arst_ox", out_x, 0);
    check("arst_oy", out_y, 0);
    exp_q.delete();
    cnt_exp = 0;
    step();
    reset_btn = 0;
    step();
    run_frame(tbl[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
